// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer with HI/LO registers. Optional perf counters via MD_SCHED_PERF_EN.
// Latency: mult/multu MULT_CYCLES busy cycles, div/divu DIV_CYCLES, then HI/LO and done; mthi/mtlo take one edge.
// Backpressure: no ready; stall holds D while an md instruction there would collide with a running op.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        d_is_md,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MD_SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_op_cnt
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy_nxt, done_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic [63:0]   pend, pend_nxt;

  logic [63:0] prod_s, prod_u;
  logic        signed_div, neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, den, quo_u, rem_u, quo, rem;

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Signed divide on magnitudes, so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign signed_div = (op == 3'd2);
  assign neg_a      = signed_div & a[31];
  assign neg_b      = signed_div & b[31];
  assign mag_a      = neg_a ? (~a + 32'd1) : a;
  assign mag_b      = neg_b ? (~b + 32'd1) : b;
  assign div_zero   = (b == 32'd0);
  assign den        = div_zero ? 32'd1 : mag_b;
  assign quo_u      = mag_a / den;
  assign rem_u      = mag_a % den;
  assign quo        = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
  assign rem        = neg_a ? (~rem_u + 32'd1) : rem_u;

  assign stall = d_is_md & (busy | (start & ~op[2]));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    pend_nxt  = pend;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              pend_nxt  = (op == 3'd0) ? prod_s : prod_u;
              cnt_nxt   = MULT_LOAD;
              state_nxt = RUN;
              busy_nxt  = 1'b1;
            end
            3'd2, 3'd3: begin
              // Divide by zero still runs full length but writes back the old HI/LO.
              pend_nxt  = div_zero ? {hi, lo} : {rem, quo};
              cnt_nxt   = DIV_LOAD;
              state_nxt = RUN;
              busy_nxt  = 1'b1;
            end
            3'd4:    hi_nxt = a;
            3'd5:    lo_nxt = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else if (cnt == '0) begin
          {hi_nxt, lo_nxt} = pend;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      pend  <= 64'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      pend  <= pend_nxt;
    end
  end

`ifdef MD_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 32'd0;
      perf_op_cnt    <= 32'd0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (done)  perf_op_cnt    <= perf_op_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-free behavioural model using 64-bit integer arithmetic.
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, cancel, d_is_md;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .d_is_md(d_is_md), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result of an md op as {hi, lo}, straight from integer arithmetic.
  function automatic logic [63:0] md_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: begin uq = ux / uy; ur = ux % uy; return {ur[31:0], uq[31:0]}; end
    endcase
  endfunction

  bit          m_busy = 0, m_done = 0, m_div0 = 0, was_busy;
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_left = 0; m_hi = 0; m_lo = 0; m_res = 0; m_div0 = 0;
    end else begin
      was_busy = m_busy;
      m_done = 0;
      if (was_busy) begin
        if (cancel) m_busy = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_done = 1;
            if (!m_div0) {m_hi, m_lo} = m_res;
          end
        end
      end else if (start) begin
        if (op < 3'd4) begin
          m_div0 = (op >= 3'd2) && (b == 32'd0);
          m_res  = m_div0 ? 64'd0 : md_result(op, a, b);
          m_left = (op < 3'd2) ? MC : DC;
          m_busy = 1;
        end else if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc hi", hi, m_hi);
      chk("cyc lo", lo, m_lo);
      chk("cyc stall", stall, d_is_md & (m_busy | (start & (op < 3'd4))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin n++; tick(); end
    chk("wait idle", busy, 1'b0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name, input int exp_n);
    int n = 0;
    issue(o, x, y);
    while (busy && n < 200) begin n++; tick(); end
    chk({name, " busy cycles"}, n, exp_n);
    chk({name, " done"}, done, 1'b1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, pulses;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; d_is_md = 1'b0; op = 3'd0; a = 0; b = 0;
    #3;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult", MC);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("done one pulse", done, 1'b0);

    run_op(3'd3, 32'd7, 32'd2, "divu", DC);
    chk("divu lo", lo, 32'd3);
    chk("divu hi", hi, 32'd1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div neg", DC);
    chk("div neg lo", lo, 32'hFFFF_FFFD);
    chk("div neg hi", hi, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", DC);
    chk("div ovf lo", lo, 32'h8000_0000);
    chk("div ovf hi", hi, 32'd0);

    issue(3'd4, 32'h11, 32'd0);
    chk("mthi busy", busy, 1'b0);
    chk("mthi hi", hi, 32'h11);
    issue(3'd5, 32'h22, 32'd0);
    chk("mtlo lo", lo, 32'h22);
    run_op(3'd3, 32'd5, 32'd0, "divu0", DC);
    chk("divu0 hi", hi, 32'h11);
    chk("divu0 lo", lo, 32'h22);

    d_is_md = 1'b1;
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    #1;
    chk("stall issue cycle", stall, 1'b1);
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    while (stall && n < 200) begin n++; tick(); end
    chk("stall busy cycles", n, MC);
    chk("stall in done cycle", stall, 1'b0);
    chk("stall done", done, 1'b1);
    d_is_md = 1'b0;
    issue(3'd0, 32'd2, 32'd3);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi in run ignored", hi, 32'd0);
    wait_idle();
    chk("after run hi", hi, 32'd0);
    chk("after run lo", lo, 32'd6);

    issue(3'd2, 32'd100, 32'd7);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel busy", busy, 1'b0);
    pulses = 0;
    repeat (12) begin if (done) pulses++; tick(); end
    chk("cancel no done", pulses, 0);
    chk("cancel hi", hi, 32'd0);
    chk("cancel lo", lo, 32'd6);

    issue(3'd0, 32'd7, 32'd9);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu", MC);
    chk("multu hi", hi, 32'd1);
    chk("multu lo", lo, 32'hFFFF_FFFE);

    repeat (3000) begin
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom_range(0, 7));
      a       = rnd_val();
      b       = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
      cancel  = ($urandom_range(0, 15) == 0);
      d_is_md = $urandom_range(0, 1) == 1;
      tick();
    end
    start = 1'b0; cancel = 1'b0; d_is_md = 1'b0;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
